// File: rtl/gcd_resp_scoreboard_if.sv
// Expected-value and GcdUnit-response channels seen by the response scoreboard.
// Both channels: a beat transfers on a rising edge where val and rdy are both high; rdy never depends on val.
interface gcd_resp_scoreboard_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  exp_val;
    logic                  exp_rdy;
    logic [DATA_WIDTH-1:0] exp_msg;
    logic                  resp_val;
    logic                  resp_rdy;
    logic [DATA_WIDTH-1:0] resp_msg;

    modport master (
        output exp_val, exp_msg, resp_val, resp_msg,
        input  exp_rdy, resp_rdy
    );

    modport slave (
        input  exp_val, exp_msg, resp_val, resp_msg,
        output exp_rdy, resp_rdy
    );
endinterface

// File: rtl/gcd_resp_scoreboard.sv
// In-order GCD response checker: expected values queue in a FIFO and are popped
// against each accepted response, with pass/fail counts, first-failure capture and hang detection.
module gcd_resp_scoreboard #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 4,
    parameter int NUM_VECTORS    = 100,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    gcd_resp_scoreboard_if.slave  bus,
    output logic [CNT_WIDTH-1:0]  pass_count,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  mismatch,
    output logic [CNT_WIDTH-1:0]  first_fail_idx,
    output logic [DATA_WIDTH-1:0] first_fail_got,
    output logic [DATA_WIDTH-1:0] first_fail_exp,
    output logic                  timeout,
    output logic                  done,
    output logic [1:0]            state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]        TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] IDX_LAST = CNT_WIDTH'(NUM_VECTORS - 1);
    localparam logic [AW:0]          OCC_FULL = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd1;
    localparam logic [1:0] ST_HUNG = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           occ_q, occ_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  pass_q, pass_d, fail_q, fail_d, ffi_q, ffi_d;
    logic [DATA_WIDTH-1:0] ffg_q, ffg_d, ffe_q, ffe_d;
    logic                  mismatch_q, mismatch_d, timeout_q, timeout_d, done_q, done_d;

    logic                  running, empty, full, exp_fire, resp_fire;
    logic [DATA_WIDTH-1:0] head;

    always_comb begin
        running   = (state_q == ST_RUN);
        empty     = (occ_q == '0);
        full      = (occ_q == OCC_FULL);
        bus.exp_rdy  = running && !full;
        bus.resp_rdy = running && !empty;
        exp_fire  = bus.exp_val && bus.exp_rdy;
        resp_fire = bus.resp_val && bus.resp_rdy;
        head      = mem_q[rd_ptr_q];

        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        tcnt_d     = tcnt_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ffi_d      = ffi_q;
        ffg_d      = ffg_q;
        ffe_d      = ffe_q;
        mismatch_d = mismatch_q;
        timeout_d  = timeout_q;
        done_d     = done_q;

        if (exp_fire) begin
            mem_d[wr_ptr_q] = bus.exp_msg;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({exp_fire, resp_fire})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (resp_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            idx_d    = idx_q + 1'b1;
            if (bus.resp_msg == head) begin
                if (pass_q != '1) pass_d = pass_q + 1'b1;
            end else begin
                if (fail_q != '1) fail_d = fail_q + 1'b1;
                mismatch_d = 1'b1;
                // Only the first failure is captured; later ones just count.
                if (!mismatch_q) begin
                    ffi_d = pass_q + fail_q;
                    ffg_d = bus.resp_msg;
                    ffe_d = head;
                end
            end
            if (idx_q == IDX_LAST) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
        end

        // Hang watchdog: only runs while something is owed and nothing is accepted.
        if (running) begin
            if (resp_fire || empty) begin
                tcnt_d = '0;
            end else if (tcnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                state_d   = ST_HUNG;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            tcnt_q     <= '0;
            idx_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ffi_q      <= '0;
            ffg_q      <= '0;
            ffe_q      <= '0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            tcnt_q     <= tcnt_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ffi_q      <= ffi_d;
            ffg_q      <= ffg_d;
            ffe_q      <= ffe_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pass_count     = pass_q;
    assign fail_count     = fail_q;
    assign mismatch       = mismatch_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_got = ffg_q;
    assign first_fail_exp = ffe_q;
    assign timeout        = timeout_q;
    assign done           = done_q;
    assign state_dbg      = state_q;
endmodule
